// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the multi-cycle byte-serial memory access controller.
package mem_access_ctrl_pkg;

  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned NB_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Data-path byte lane served by transfer step idx (reversed for big-endian).
  function automatic logic [IDX_W-1:0] lane_of(input logic [IDX_W-1:0] idx,
                                               input logic [NB_W-1:0]  nbytes,
                                               input logic             big_endian);
    logic [NB_W-1:0] rev;
    rev = nbytes - NB_W'(1) - {1'b0, idx};
    return big_endian ? rev[IDX_W-1:0] : idx;
  endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Serialises byte/half/word accesses from the wide data path onto a byte-wide memory.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned BIG_ENDIAN  = 0,
  parameter int unsigned ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_rd,
  output logic              mem_wr
);

  localparam int unsigned BYTES = DATA_W / 8;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [NB_W-1:0]   nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              errf_q, errf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_d;

  logic              bad_size, misalign, bad_req;
  logic [IDX_W-1:0]  lane_cur, lane_nxt;

  logic              ack_nx, err_nx, busy_nx, mem_rd_nx, mem_wr_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic [7:0]        mem_wdata_nx;

  // Request legality: unsupported size or (when checked) address not a multiple of size.
  always_comb begin
    bad_size = (size == 2'd3) || ((size == SZ_WORD) && (DATA_W == 16));
    misalign = 1'b0;
    case (size)
      SZ_HALF: misalign = addr[0];
      SZ_WORD: misalign = |addr[1:0];
      default: misalign = 1'b0;
    endcase
    bad_req = bad_size || ((ALIGN_CHECK != 0) && misalign);
  end

  assign lane_cur = lane_of(idx_q, nbytes_q, BIG_ENDIAN != 0);
  assign lane_nxt = lane_of(idx_d, nbytes_d, BIG_ENDIAN != 0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of the latched request, byte index, wait counter and read data.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    nbytes_d = nbytes_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    errf_d   = errf_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          we_d     = we;
          addr_d   = addr;
          wdata_d  = wdata;
          nbytes_d = NB_W'(1) << size;
          idx_d    = '0;
          cnt_d    = '0;
          if (bad_req) begin
            errf_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            errf_d  = 1'b0;
            rdata_d = '0;
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
          if (!we_q) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
              if (lane_cur == IDX_W'(b)) rdata_d[b*8 +: 8] = mem_rdata;
            end
          end
          if ({1'b0, idx_q} == nbytes_q - NB_W'(1)) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered without extra latency.
  always_comb begin
    ack_nx       = 1'b0;
    err_nx       = 1'b0;
    busy_nx      = (state_d != ST_IDLE);
    mem_rd_nx    = 1'b0;
    mem_wr_nx    = 1'b0;
    mem_addr_nx  = '0;
    mem_wdata_nx = '0;
    if (state_d == ST_DONE) begin
      ack_nx = 1'b1;
      err_nx = errf_d;
    end
    if (state_d == ST_ACCESS) begin
      mem_rd_nx   = !we_d;
      mem_wr_nx   = we_d;
      mem_addr_nx = addr_d + ADDR_W'(idx_d);
      if (we_d) begin
        for (int unsigned b = 0; b < BYTES; b++) begin
          if (lane_nxt == IDX_W'(b)) mem_wdata_nx = wdata_d[b*8 +: 8];
        end
      end
    end
  end

  // Latched request fields, step counters and read-data assembly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      nbytes_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      errf_q   <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      rdata    <= '0;
    end else begin
      we_q     <= we_d;
      nbytes_q <= nbytes_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      errf_q   <= errf_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rdata    <= rdata_d;
    end
  end

  // Output registers; reset drops strobes immediately, even mid-access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack       <= ack_nx;
      err       <= err_nx;
      busy      <= busy_nx;
      mem_rd    <= mem_rd_nx;
      mem_wr    <= mem_wr_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three controller configurations sharing one byte memory model.
module tb_mem_access_ctrl;

  localparam int NI = 3;
  localparam int DWS [NI] = '{16, 16, 32};
  localparam int WCS [NI] = '{0, 2, 1};
  localparam int BES [NI] = '{0, 1, 0};
  localparam int ACS [NI] = '{1, 0, 1};

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic        we;
  logic [1:0]  size;
  logic [15:0] addr;
  logic [31:0] wdata;

  logic [15:0] rdata_0, rdata_1;
  logic [31:0] rdata_2;
  logic        ack_0, ack_1, ack_2, err_0, err_1, err_2, busy_0, busy_1, busy_2;
  logic        mrd_0, mrd_1, mrd_2, mwr_0, mwr_1, mwr_2;
  logic [15:0] ma_0, ma_1, ma_2;
  logic [7:0]  mwd_0, mwd_1, mwd_2, mrdat_0, mrdat_1, mrdat_2;

  logic [7:0]  mem [0:65535];

  logic [31:0] rd_v [NI];
  logic [15:0] ma_v [NI];
  logic [7:0]  mwd_v [NI];
  logic [2:0]  ack_v, err_v, busy_v, mrd_v, mwr_v;

  typedef struct {
    int          inst;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [7:0]  d;
  } tr_t;

  exp_t        sbq [$];
  tr_t         exp_tr [$];
  tr_t         act_tr [$];
  logic [31:0] last_rd [NI];
  int          cyc = 0;
  int          issue_cyc = 0;
  int          done_cnt = 0;
  int          ack_cnt [NI];
  int          checks = 0;
  int          errors = 0;

  mem_access_ctrl #(.DATA_W(DWS[0]), .ADDR_W(16), .WAIT_CYCLES(WCS[0]), .BIG_ENDIAN(BES[0]), .ALIGN_CHECK(ACS[0])) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we), .size(size), .addr(addr), .wdata(wdata[15:0]),
    .rdata(rdata_0), .ack(ack_0), .err(err_0), .busy(busy_0), .mem_addr(ma_0), .mem_wdata(mwd_0),
    .mem_rdata(mrdat_0), .mem_rd(mrd_0), .mem_wr(mwr_0));

  mem_access_ctrl #(.DATA_W(DWS[1]), .ADDR_W(16), .WAIT_CYCLES(WCS[1]), .BIG_ENDIAN(BES[1]), .ALIGN_CHECK(ACS[1])) u_dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we), .size(size), .addr(addr), .wdata(wdata[15:0]),
    .rdata(rdata_1), .ack(ack_1), .err(err_1), .busy(busy_1), .mem_addr(ma_1), .mem_wdata(mwd_1),
    .mem_rdata(mrdat_1), .mem_rd(mrd_1), .mem_wr(mwr_1));

  mem_access_ctrl #(.DATA_W(DWS[2]), .ADDR_W(16), .WAIT_CYCLES(WCS[2]), .BIG_ENDIAN(BES[2]), .ALIGN_CHECK(ACS[2])) u_dut2 (
    .clk(clk), .reset(reset), .req(req[2]), .we(we), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata_2), .ack(ack_2), .err(err_2), .busy(busy_2), .mem_addr(ma_2), .mem_wdata(mwd_2),
    .mem_rdata(mrdat_2), .mem_rd(mrd_2), .mem_wr(mwr_2));

  assign mrdat_0 = mem[ma_0];
  assign mrdat_1 = mem[ma_1];
  assign mrdat_2 = mem[ma_2];

  always_comb begin
    rd_v[0] = {16'h0, rdata_0};
    rd_v[1] = {16'h0, rdata_1};
    rd_v[2] = rdata_2;
    ma_v[0] = ma_0;  ma_v[1] = ma_1;  ma_v[2] = ma_2;
    mwd_v[0] = mwd_0; mwd_v[1] = mwd_1; mwd_v[2] = mwd_2;
    ack_v  = {ack_2, ack_1, ack_0};
    err_v  = {err_2, err_1, err_0};
    busy_v = {busy_2, busy_1, busy_0};
    mrd_v  = {mrd_2, mrd_1, mrd_0};
    mwr_v  = {mwr_2, mwr_1, mwr_0};
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: collect strobe trace, and on ack pop the scoreboard and compare.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NI; i++) begin
        if (mrd_v[i] || mwr_v[i]) begin
          act_tr.push_back('{w: mwr_v[i], a: ma_v[i], d: (mwr_v[i] ? mwd_v[i] : 8'h00)});
        end
        if (ack_v[i]) begin
          ack_cnt[i]++;
          done_cnt++;
          chk("ack_pending", 32'(sbq.size()), 32'd1);
          if (sbq.size() > 0) begin
            exp_t e;
            int n;
            e = sbq.pop_front();
            chk("ack_inst", 32'(i), 32'(e.inst));
            chk("err", 32'(err_v[i]), 32'(e.err));
            chk("rdata", rd_v[i], e.rdata);
            chk("latency", 32'(cyc - issue_cyc), 32'(e.lat));
            chk("busy_at_ack", 32'(busy_v[i]), 32'd1);
            chk("trace_len", 32'(act_tr.size()), 32'(exp_tr.size()));
            n = (act_tr.size() < exp_tr.size()) ? act_tr.size() : exp_tr.size();
            for (int k = 0; k < n; k++) begin
              chk("trace", {7'h0, act_tr[k].w, act_tr[k].a, act_tr[k].d},
                           {7'h0, exp_tr[k].w, exp_tr[k].a, exp_tr[k].d});
            end
          end
          act_tr.delete();
          exp_tr.delete();
        end
      end
    end
  end

  // Drive one request to instance i, build its expectation, and wait (bounded) for completion.
  task automatic issue(input int i, input logic w, input logic [1:0] sz,
                       input logic [15:0] a, input logic [31:0] wd);
    exp_t        e;
    int          nb;
    int          d0;
    logic        bad;
    logic [31:0] r;
    logic [15:0] ab;
    int          lane;
    nb  = 1 << sz;
    bad = (sz == 2'd3) || (sz == 2'd2 && DWS[i] == 16) || (ACS[i] != 0 && (int'(a) % nb) != 0);
    e.inst = i;
    e.err  = bad;
    if (bad) begin
      e.lat   = 1;
      e.rdata = last_rd[i];
    end else begin
      e.lat = nb * (WCS[i] + 1) + 1;
      r = 32'h0;
      for (int b = 0; b < nb; b++) begin
        ab   = a + 16'(b);
        lane = (BES[i] != 0) ? (nb - 1 - b) : b;
        if (!w) r[lane*8 +: 8] = mem[ab];
        for (int k = 0; k <= WCS[i]; k++) begin
          exp_tr.push_back('{w: w, a: ab, d: (w ? wd[lane*8 +: 8] : 8'h00)});
        end
      end
      e.rdata    = r;
      last_rd[i] = r;
    end
    sbq.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    we = w; size = sz; addr = a; wdata = wd;
    req[i] = 1'b1;
    issue_cyc = cyc;
    @(posedge clk);
    #1 req[i] = 1'b0;
    for (int t = 0; t < 100 && done_cnt == d0; t++) @(negedge clk);
    chk("completed", 32'(done_cnt - d0), 32'd1);
    if (done_cnt == d0) begin
      sbq.delete();
      exp_tr.delete();
      act_tr.delete();
    end
    @(negedge clk);
    chk("busy_after", 32'(busy_v[i]), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int found;
    reset = 1'b0;
    req   = 3'b000;
    we    = 1'b0;
    size  = 2'd0;
    addr  = 16'h0;
    wdata = 32'h0;
    for (int j = 0; j < 65536; j++) mem[j] = 8'(j * 37 + 11);
    mem[16'h0010] = 8'h34;
    mem[16'h0011] = 8'h12;
    mem[16'h0102] = 8'h9C;
    mem[16'hFFFF] = 8'h5A;
    mem[16'h0000] = 8'hA5;
    for (int i = 0; i < NI; i++) begin
      last_rd[i] = 32'h0;
      ack_cnt[i] = 0;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_rdata", rd_v[i], 32'h0);
      chk("rst_addr", {16'h0, ma_v[i]}, 32'h0);
    end
    chk("rst_ctrl", {17'h0, ack_v, err_v, busy_v, mrd_v, mwr_v}, 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 16-bit little-endian, no wait states, alignment checked
    issue(0, 1'b0, 2'd1, 16'h0010, 32'h0);
    chk("tp_half_read", rd_v[0], 32'h0000_1234);
    issue(0, 1'b0, 2'd1, 16'h0003, 32'h0);
    chk("tp_misalign_keep", rd_v[0], 32'h0000_1234);
    issue(0, 1'b1, 2'd2, 16'h0004, 32'h1111);
    issue(0, 1'b0, 2'd3, 16'h0008, 32'h0);
    issue(0, 1'b1, 2'd0, 16'h0041, 32'h0077);

    // 16-bit big-endian, two wait states, unaligned allowed
    issue(1, 1'b1, 2'd1, 16'h0020, 32'hABCD);
    issue(1, 1'b0, 2'd1, 16'h0003, 32'h0);
    issue(1, 1'b0, 2'd1, 16'hFFFF, 32'h0);
    chk("tp_wrap_be", rd_v[1], 32'h0000_5AA5);
    issue(1, 1'b0, 2'd0, 16'h0005, 32'h0);

    // 32-bit little-endian, one wait state, alignment checked
    issue(2, 1'b0, 2'd0, 16'h0102, 32'h0);
    chk("tp_byte32", rd_v[2], 32'h0000_009C);
    issue(2, 1'b0, 2'd2, 16'h0100, 32'h0);
    issue(2, 1'b0, 2'd3, 16'h0100, 32'h0);
    issue(2, 1'b1, 2'd2, 16'h0200, 32'h1122_3344);
    issue(2, 1'b1, 2'd1, 16'h0201, 32'h5566);
    issue(2, 1'b0, 2'd1, 16'h0202, 32'h0);

    // Reset during the second byte of a word write
    a0 = ack_cnt[2];
    @(negedge clk);
    we = 1'b1; size = 2'd2; addr = 16'h0300; wdata = 32'hDEAD_BEEF;
    req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      @(negedge clk);
      if (mwr_v[2] && ma_v[2] == 16'h0301) found = 1;
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(mwr_v[2]), 32'd0);
    chk("rst_mid_busy", 32'(busy_v[2]), 32'd0);
    chk("rst_mid_ack", 32'(ack_v[2]), 32'd0);
    act_tr.delete();
    exp_tr.delete();
    for (int i = 0; i < NI; i++) last_rd[i] = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_no_ack", 32'(ack_cnt[2]), 32'(a0));
    issue(2, 1'b0, 2'd2, 16'h0304, 32'h0);

    // Random mix across all three configurations
    for (int n = 0; n < 24; n++) begin
      issue($urandom_range(0, 2), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
